// File: rtl/joy_pkg.sv
// Shared definitions for the joystick debounce/autofire block.
// Holds joystick bit indices, the released (all-high) port value, default timing
// parameters and the helper that composes one output port from debounced bits.
package joy_pkg;

    localparam int unsigned RIGHT = 0;
    localparam int unsigned LEFT  = 1;
    localparam int unsigned DOWN  = 2;
    localparam int unsigned UP    = 3;
    localparam int unsigned FIRE1 = 4;
    localparam int unsigned FIRE2 = 5;

    // Active-low inputs: all ones means nothing pressed.
    localparam logic [5:0] RELEASED = 6'h3F;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 28000;    // 1 ms at 28 MHz
    localparam int unsigned DEF_AUTOFIRE_HALF   = 1400000;  // 10 Hz at 28 MHz

    // Directions and fire2 pass straight through (opposite directions are not
    // filtered). Fire1 is OR-ed with the autofire phase while autofire is on,
    // so a high phase reads as "released".
    function automatic logic [5:0] compose_port(input logic [5:0] db,
                                                input logic       phase,
                                                input logic       af);
        logic [5:0] port;
        port        = RELEASED;
        port[RIGHT] = db[RIGHT];
        port[LEFT]  = db[LEFT];
        port[DOWN]  = db[DOWN];
        port[UP]    = db[UP];
        port[FIRE2] = db[FIRE2];
        port[FIRE1] = db[FIRE1] | (af & phase);
        return port;
    endfunction

endpackage

// File: rtl/joy_debounce_autofire_if.sv
// Signal bundle between the MCP23S17 expander stage and the joystick
// debounce/autofire block.
//   ready_in  : expander configured; joystick inputs valid only while high
//   joya_in   : joystick 1, active-low {fire2, fire1, up, down, left, right}
//   joyb_in   : joystick 2, same bit map
//   af_en     : autofire enable, bit0 port A, bit1 port B
//   joya_out  : debounced/autofired joystick 1
//   joyb_out  : debounced/autofired joystick 2
//   changed   : one-cycle pulse after any output bit changed
// master = expander/system side, slave = the debounce/autofire block.
interface joy_debounce_autofire_if;

    logic       ready_in;
    logic [5:0] joya_in;
    logic [5:0] joyb_in;
    logic [1:0] af_en;
    logic [5:0] joya_out;
    logic [5:0] joyb_out;
    logic       changed;

    modport master (
        output ready_in,
        output joya_in,
        output joyb_in,
        output af_en,
        input  joya_out,
        input  joyb_out,
        input  changed
    );

    modport slave (
        input  ready_in,
        input  joya_in,
        input  joyb_in,
        input  af_en,
        output joya_out,
        output joyb_out,
        output changed
    );

endinterface

// File: rtl/debounce_bit.sv
// Single-bit debouncer.
//   clk    : system clock
//   rst    : asynchronous active-high reset (state = 1, count = 0)
//   sample : raw input bit
//   state  : debounced bit; follows sample only after it has differed for
//            DEBOUNCE_CYCLES consecutive cycles
module debounce_bit
    import joy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sample,
    output logic state
);

    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] count;

    // Any cycle where the input agrees with the state restarts the count,
    // so glitches shorter than DEBOUNCE_CYCLES never reach the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= 1'b1;
            count <= '0;
        end else if (sample == state) begin
            count <= '0;
        end else if (count == LAST) begin
            state <= sample;
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/joy_debounce_autofire.sv
// Joystick debounce and autofire for two 6-bit active-low ports.
//   clk : 28 MHz system clock
//   rst : asynchronous active-high reset
//   bus : joy_debounce_autofire_if.slave (inputs, autofire enables, outputs,
//         change pulse)
// Each of the 12 input bits is debounced separately; fire1 of each port feeds
// an autofire engine whose phase is OR-ed into the output while enabled.
module joy_debounce_autofire
    import joy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned AUTOFIRE_HALF   = DEF_AUTOFIRE_HALF
) (
    input  logic                    clk,
    input  logic                    rst,
    joy_debounce_autofire_if.slave  bus
);

    localparam logic [20:0] AF_LAST = 21'(AUTOFIRE_HALF - 1);

    logic [11:0] effective;
    logic [11:0] db;
    logic [1:0]  phase;
    logic [11:0] out_next;
    logic [11:0] out_reg;
    logic        changed_reg;

    // Before the expander is configured its pins are meaningless; present
    // "released" so the debounced state drifts back to idle.
    assign effective = bus.ready_in ? {bus.joyb_in, bus.joya_in} : {RELEASED, RELEASED};

    for (genvar i = 0; i < 12; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk    (clk),
            .rst    (rst),
            .sample (effective[i]),
            .state  (db[i])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_af
        logic [20:0] af_count;
        logic        af_phase;

        // Released fire1 holds the engine at count 0 / phase 0, so the edge on
        // which fire1 goes low always starts from a fresh pressed half-period.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                af_count <= '0;
                af_phase <= 1'b0;
            end else if (db[p*6 + FIRE1]) begin
                af_count <= '0;
                af_phase <= 1'b0;
            end else if (af_count == AF_LAST) begin
                af_count <= '0;
                af_phase <= ~af_phase;
            end else begin
                af_count <= af_count + 21'd1;
            end
        end

        assign phase[p] = af_phase;
    end

    assign out_next = {compose_port(db[11:6], phase[1], bus.af_en[1]),
                       compose_port(db[5:0],  phase[0], bus.af_en[0])};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg     <= {RELEASED, RELEASED};
            changed_reg <= 1'b0;
        end else begin
            out_reg     <= out_next;
            changed_reg <= (out_next != out_reg);
        end
    end

    assign bus.joya_out = out_reg[5:0];
    assign bus.joyb_out = out_reg[11:6];
    assign bus.changed  = changed_reg;

endmodule

// File: tb/tb_joy_debounce_autofire.sv
// Self-checking bench for joy_debounce_autofire with DEBOUNCE_CYCLES=4,
// AUTOFIRE_HALF=8. A sample-history/elapsed-time model is compared against
// the DUT on every falling clock edge; directed scenarios add literal checks.
module tb_joy_debounce_autofire;

    localparam int D = 4;
    localparam int H = 8;

    logic clk;
    logic rst;

    joy_debounce_autofire_if bus ();

    joy_debounce_autofire #(
        .DEBOUNCE_CYCLES (D),
        .AUTOFIRE_HALF   (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // Debounced bit flips once the last D samples all disagree with it.
    // Autofire phase = parity of whole half-periods elapsed since the press.
    logic [11:0] m_db;
    logic [11:0] m_out;
    logic        m_changed;
    logic [11:0] m_hist[$];
    int          m_n;
    int          m_press[2];

    task automatic model_reset();
        m_db       = 12'hFFF;
        m_out      = 12'hFFF;
        m_changed  = 1'b0;
        m_hist.delete();
        m_n        = 0;
        m_press[0] = 0;
        m_press[1] = 0;
    endtask

    task automatic model_step();
        logic [11:0] eff;
        logic [11:0] nxt;
        logic [11:0] old;
        bit          ph;
        bit          all_diff;
        eff = bus.ready_in ? {bus.joyb_in, bus.joya_in} : 12'hFFF;
        nxt = m_db;
        for (int p = 0; p < 2; p++) begin
            ph = (m_db[p*6 + 4] == 1'b0) && ((((m_n - m_press[p] - 1) / H) % 2) == 1);
            if (bus.af_en[p] && ph) nxt[p*6 + 4] = 1'b1;
        end
        m_changed = (nxt != m_out);
        m_out     = nxt;
        m_hist.push_back(eff);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        old = m_db;
        if (m_hist.size() == D) begin
            for (int b = 0; b < 12; b++) begin
                all_diff = 1'b1;
                foreach (m_hist[k]) if (m_hist[k][b] == old[b]) all_diff = 1'b0;
                if (all_diff) m_db[b] = ~old[b];
            end
        end
        for (int p = 0; p < 2; p++)
            if (old[p*6 + 4] && !m_db[p*6 + 4]) m_press[p] = m_n;
        m_n++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            check("model_joya", bus.joya_out, m_out[5:0]);
            check("model_joyb", bus.joyb_out, m_out[11:6]);
            check("model_changed", {5'b0, bus.changed}, {5'b0, m_changed});
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst          = 1'b1;
        bus.ready_in = 1'b1;
        bus.joya_in  = 6'h00;
        bus.joyb_in  = 6'h3F;
        bus.af_en    = 2'b00;

        // Reset, then all-pressed port A appears on the 5th edge.
        repeat (3) tick();
        check("rst_joya", bus.joya_out, 6'h3F);
        check("rst_changed", {5'b0, bus.changed}, 6'h00);
        rst = 1'b0;
        repeat (4) tick();
        check("lat_joya_edge4", bus.joya_out, 6'h3F);
        tick();
        check("lat_joya_edge5", bus.joya_out, 6'h00);
        check("lat_changed_pulse", {5'b0, bus.changed}, 6'h01);
        tick();
        check("lat_changed_end", {5'b0, bus.changed}, 6'h00);

        // Glitch of 3 cycles on right is filtered.
        bus.joya_in = 6'h3F;
        repeat (8) tick();
        bus.joya_in = 6'h3E;
        repeat (3) tick();
        bus.joya_in = 6'h3F;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_joya", bus.joya_out, 6'h3F);
            check("glitch_changed", {5'b0, bus.changed}, 6'h00);
        end

        // Autofire on port A: 8 low / 8 high, then release at start of low phase.
        bus.af_en   = 2'b01;
        bus.joya_in = 6'h2F;
        repeat (4) tick();
        for (int i = 0; i < 17; i++) begin
            tick();
            check("af_bit4", {5'b0, bus.joya_out[4]}, 6'((i / 8) % 2));
        end
        bus.joya_in = 6'h3F;
        repeat (4) begin
            tick();
            check("af_release_low", {5'b0, bus.joya_out[4]}, 6'h00);
        end
        tick();
        check("af_release_high", {5'b0, bus.joya_out[4]}, 6'h01);
        repeat (10) tick();

        // af_en off during press, then enabled mid-press while phase is 0.
        bus.af_en   = 2'b00;
        bus.joya_in = 6'h2F;
        for (int t = 1; t <= 22; t++) begin
            tick();
            if (t >= 5) check("noaf_bit4", {5'b0, bus.joya_out[4]}, 6'h00);
        end
        bus.af_en = 2'b01;
        for (int t = 23; t <= 28; t++) begin
            tick();
            check("afon_low", {5'b0, bus.joya_out[4]}, 6'h00);
        end
        tick();
        check("afon_high_29", {5'b0, bus.joya_out[4]}, 6'h01);
        repeat (7) tick();
        tick();
        check("afon_low_37", {5'b0, bus.joya_out[4]}, 6'h00);
        bus.joya_in = 6'h3F;
        bus.af_en   = 2'b00;
        repeat (12) tick();

        // ready_in low forces port B back to released.
        bus.joyb_in = 6'h00;
        repeat (6) tick();
        check("joyb_pressed", bus.joyb_out, 6'h00);
        bus.ready_in = 1'b0;
        repeat (4) begin
            tick();
            check("ready_hold", bus.joyb_out, 6'h00);
        end
        tick();
        check("ready_released", bus.joyb_out, 6'h3F);
        bus.ready_in = 1'b1;
        repeat (6) tick();
        check("joyb_again", bus.joyb_out, 6'h00);

        // Reset two cycles into a count: immediate, and the count restarts.
        bus.joya_in = 6'h00;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_joya", bus.joya_out, 6'h3F);
        check("async_rst_joyb", bus.joyb_out, 6'h3F);
        check("async_rst_changed", {5'b0, bus.changed}, 6'h00);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_edge4", bus.joya_out, 6'h3F);
        tick();
        check("post_rst_edge5_a", bus.joya_out, 6'h00);
        check("post_rst_edge5_b", bus.joyb_out, 6'h00);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/joy_debounce_autofire.md
JOY_DEBOUNCE_AUTOFIRE -- requirements
Module: joy_debounce_autofire

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 28000, cycles (1 ms at 28 MHz) an input bit must differ from its debounced state before the debounced state changes; legal range 1..65535.
REQ-002 Parameter AUTOFIRE_HALF, default 1400000, cycles per autofire half-period (10 Hz at 28 MHz); legal range 1..2^21-1.
REQ-003 clk  input  1  28 MHz system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ready_in  input  1  high when the MCP23S17 input stage is configured; joystick inputs are valid only while high.
REQ-006 joya_in  input  6  joystick 1 from the expander stage, active-low: bit5 fire2, bit4 fire1, bit3 up, bit2 down, bit1 left, bit0 right.
REQ-007 joyb_in  input  6  joystick 2, same bit map as joya_in.
REQ-008 af_en  input  2  autofire enable; bit0 applies to port A, bit1 to port B; sampled every cycle.
REQ-009 joya_out  output  6  debounced/autofired joystick 1, registered, same bit map and polarity.
REQ-010 joyb_out  output  6  debounced/autofired joystick 2.
REQ-011 changed  output  1  one-cycle pulse when any bit of joya_out or joyb_out changes value.

Function
REQ-012 While ready_in is low, each effective input bit SHALL be forced to 1 (released) ahead of the debounce stage; the forced value is debounced like any other.
REQ-013 Each of the 12 bits SHALL own a 16-bit counter and a debounced state bit.
REQ-014 Input equal to debounced state: counter cleared to 0.
REQ-015 Input differs: counter increments; in the cycle the counter equals DEBOUNCE_CYCLES-1, debounced state takes the input value and counter clears.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the debounced state unchanged; any return to the debounced value restarts the count from 0.
REQ-017 Latency: an input stable from cycle T updates the debounced state at edge T+DEBOUNCE_CYCLES and the output register one edge later.
REQ-018 Output bits 5 and 3..0 SHALL equal the debounced bits, registered.
REQ-019 Per port, an autofire engine SHALL hold a 21-bit counter and a phase bit (0 = pressed).
REQ-020 Debounced fire1 falling edge (press): counter cleared, phase = 0 in the same edge.
REQ-021 While debounced fire1 = 0: counter increments; at AUTOFIRE_HALF-1 the counter clears and phase toggles.
REQ-022 While debounced fire1 = 1: counter held at 0, phase held at 0.
REQ-023 Output bit4 = debounced fire1 when af_en for that port is 0; = debounced fire1 OR phase when af_en is 1.
REQ-024 af_en changing mid-press SHALL take effect on the next output register update without restarting the phase.
REQ-025 Simultaneous opposite directions (up+down, left+right) SHALL pass through unmodified.
REQ-026 changed SHALL be 1 for exactly the cycle after an output register update that altered any bit; simultaneous changes on both ports produce one pulse.

Reset
REQ-027 On rst: joya_out = joyb_out = 6'h3F, changed = 0, all debounced states = 1, all counters = 0, phases = 0, effective immediately and asynchronously.
REQ-028 Reset asserted mid-count or mid-autofire SHALL discard the partial count; after release the block behaves as from power-up.

Structure
REQ-029 Shared package joy_pkg SHALL hold the bit-index constants (RIGHT=0 .. FIRE2=5), released value 6'h3F, and the default DEBOUNCE_CYCLES / AUTOFIRE_HALF values.
REQ-030 Sub-module debounce_bit (one input bit, counter, state; parameter DEBOUNCE_CYCLES) SHALL be instantiated 12 times; autofire logic stays in the top module.

Verification (DEBOUNCE_CYCLES=4, AUTOFIRE_HALF=8)
REQ-031 Reset: rst high for 3 cycles with joya_in=6'h00 -> outputs 6'h3F, changed 0; after release with ready_in=1, joya_out=6'h00 on the 5th edge, changed pulses once.
REQ-032 Glitch: joya_in bit0 low for 3 cycles then high -> joya_out stays 6'h3F, changed never pulses.
REQ-033 Autofire: af_en=01, joya_in=6'h2F held -> joya_out bit4 low 8 cycles, high 8, low 8, repeating; release -> bit4 high after 4 stable cycles plus 1.
REQ-034 af_en=00 with same press -> bit4 stays low steadily; set af_en=01 mid-press -> toggling starts on the next phase edge.
REQ-035 ready_in falls while joyb_in=6'h00 -> joyb_out returns to 6'h3F 5 edges later.
REQ-036 Reset asserted 2 cycles into a debounce count -> outputs 6'h3F immediately; post-release count restarts from 0.
